// File: rtl/clk_div_multi.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// clk_div_multi
//
// Multi-channel programmable clock divider and tick generator. Each channel
// counts 0..div-1 at the system clock and produces:
//   - tick    : one-cycle marker in the cycle after the counter wraps
//   - div_clk : square wave (toggle mode) or a copy of tick (pulse mode)
// Divisor writes land in a shadow register and are committed on a wrap, while
// the channel is disabled, or on the shared sync strobe. Committing only at
// those points keeps every period whole.
//
// Ports:
//   clk     in   system clock
//   rst     in   asynchronous reset, active low
//   en      in   [CH]   per-channel enable (level)
//   mode    in   [CH]   per-channel mode, 0 = toggle, 1 = pulse
//   wr_en   in          divisor write strobe (one cycle)
//   wr_ch   in   [CHW]  channel index for the write; values >= CH are ignored
//   wr_div  in   [W]    new divisor; 0 and 1 are clamped to 2
//   sync    in          restart and phase-align all channels (one cycle)
//   div_clk out  [CH]   divided clock or pulse copy, registered
//   tick    out  [CH]   one-cycle period marker, registered
// -----------------------------------------------------------------------------
module clk_div_multi #(
    parameter int CH          = 4,
    parameter int CHW         = 2,
    parameter int W           = 17,
    parameter int DEFAULT_DIV = 100000
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [CH-1:0]  en,
    input  logic [CH-1:0]  mode,
    input  logic           wr_en,
    input  logic [CHW-1:0] wr_ch,
    input  logic [W-1:0]   wr_div,
    input  logic           sync,
    output logic [CH-1:0]  div_clk,
    output logic [CH-1:0]  tick
);

    localparam logic [W-1:0] DIV_RST = W'(DEFAULT_DIV);
    localparam logic [W-1:0] DIV_MIN = W'(2);

    // A divisor below 2 has no valid 0..div-1 counting range.
    logic [W-1:0] wr_div_clamped;
    assign wr_div_clamped = (wr_div < DIV_MIN) ? DIV_MIN : wr_div;

    for (genvar i = 0; i < CH; i++) begin : g_ch
        logic [W-1:0] cnt_q, cnt_d;
        logic [W-1:0] div_act_q, div_act_d;
        logic [W-1:0] div_shd_q, div_shd_d;
        logic         mode_act_q, mode_act_d;
        logic         div_clk_q, div_clk_d;
        logic         tick_q, tick_d;
        logic         wr_hit;
        logic         wrap;
        logic         commit;
        logic [W-1:0] half;

        // Equality against this channel's own index means an out-of-range
        // wr_ch matches no channel at all.
        assign wr_hit = wr_en && (wr_ch == CHW'(i));
        assign wrap   = en[i] && (cnt_q == div_act_q - W'(1));
        assign commit = wrap || !en[i] || sync;
        assign half   = div_act_q >> 1;

        always_comb begin
            // NOTE: every signal written here gets a default first, so no path
            // leaves one unassigned and no latch can be inferred.
            div_shd_d  = wr_hit ? wr_div_clamped : div_shd_q;
            div_act_d  = div_act_q;
            mode_act_d = mode_act_q;
            cnt_d      = '0;
            div_clk_d  = 1'b0;
            tick_d     = 1'b0;

            // Commit reads div_shd_d, so a write in the commit cycle goes
            // straight into the active divisor.
            if (commit) begin
                div_act_d  = div_shd_d;
                mode_act_d = mode[i];
            end

            // Disabled or sync: counter and outputs stay at zero. Sync wins
            // over a coincident wrap.
            if (en[i] && !sync) begin
                cnt_d  = wrap ? '0 : cnt_q + W'(1);
                tick_d = wrap;
                // Toggle output as a level of the next count: low for
                // 0..half-1, high for half..div-1. The wrap cycle still uses
                // the outgoing mode, so entering pulse mode drops the clock.
                div_clk_d = mode_act_q ? wrap : (cnt_d >= half);
            end
        end

        // NOTE: the divisor and mode registers are reset along with the
        // counter so every channel restarts at DEFAULT_DIV without a write.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                cnt_q      <= '0;
                div_act_q  <= DIV_RST;
                div_shd_q  <= DIV_RST;
                mode_act_q <= 1'b0;
                div_clk_q  <= 1'b0;
                tick_q     <= 1'b0;
            end else begin
                // NOTE: non-blocking assignments so every register samples
                // the pre-edge state, independent of statement order.
                cnt_q      <= cnt_d;
                div_act_q  <= div_act_d;
                div_shd_q  <= div_shd_d;
                mode_act_q <= mode_act_d;
                div_clk_q  <= div_clk_d;
                tick_q     <= tick_d;
            end
        end

        assign div_clk[i] = div_clk_q;
        assign tick[i]    = tick_q;
    end

endmodule

// File: tb/tb_clk_div_multi.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_clk_div_multi
//
// Directed bench for clk_div_multi. Channels 0..3 belong to a 4-channel
// instance (DEFAULT_DIV=10); channels 4..6 belong to a 3-channel instance
// (DEFAULT_DIV=4) used for the out-of-range write case. Each channel's expected
// waveform is described by hand-placed segments (start edge, phase origin,
// divisor, mode). The stimulus pushes the per-cycle expectation into a queue
// and a negedge monitor pops and compares it.
// -----------------------------------------------------------------------------
module tb_clk_div_multi;

    localparam int CH   = 4;
    localparam int CH3  = 3;
    localparam int NCH  = CH + CH3;

    logic           clk = 1'b0;
    logic           rst;
    logic [CH-1:0]  en, mode, div_clk, tick;
    logic           wr_en, sync;
    logic [1:0]     wr_ch;
    logic [16:0]    wr_div;
    logic [CH3-1:0] en3, mode3, div_clk3, tick3;
    logic           wr_en3, sync3;
    logic [1:0]     wr_ch3;
    logic [7:0]     wr_div3;

    always #5 clk = ~clk;

    clk_div_multi #(.CH(CH), .CHW(2), .W(17), .DEFAULT_DIV(10)) u_dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .wr_en(wr_en),
        .wr_ch(wr_ch), .wr_div(wr_div), .sync(sync),
        .div_clk(div_clk), .tick(tick)
    );

    clk_div_multi #(.CH(CH3), .CHW(2), .W(8), .DEFAULT_DIV(4)) u_dut3 (
        .clk(clk), .rst(rst), .en(en3), .mode(mode3), .wr_en(wr_en3),
        .wr_ch(wr_ch3), .wr_div(wr_div3), .sync(sync3),
        .div_clk(div_clk3), .tick(tick3)
    );

    typedef struct {
        int ch;
        int from;
        int e0;
        int d;
        bit md;
        bit on;
    } seg_t;

    typedef struct {
        int         cyc;
        int         ch;
        logic [1:0] val;
    } exp_t;

    seg_t segs[$];
    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    bit   run      = 0;

    always @(posedge clk) if (run) cyc = cyc + 1;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    task automatic seg(input int ch, input int from, input int e0, input int d,
                       input bit md, input bit on);
        seg_t s;
        s.ch = ch; s.from = from; s.e0 = e0; s.d = d; s.md = md; s.on = on;
        segs.push_back(s);
    endtask

    // {div_clk, tick} after edge n. k counts enabled edges since the phase
    // origin e0; tick when k is a multiple of d, high phase when k mod d >= d/2.
    function automatic logic [1:0] model(input int ch, input int n);
        seg_t s;
        bit   found = 0;
        int   k, r;
        logic t, dc;
        foreach (segs[j]) if (segs[j].ch == ch && segs[j].from <= n) begin
            s = segs[j];
            found = 1;
        end
        if (!found || !s.on) return 2'b00;
        k = n - s.e0 + 1;
        if (k <= 0) return 2'b00;
        r  = k % s.d;
        t  = (r == 0);
        dc = s.md ? t : (r >= s.d / 2);
        return {dc, t};
    endfunction

    function automatic logic [1:0] dut_out(input int ch);
        if (ch < CH) return {div_clk[ch], tick[ch]};
        return {div_clk3[ch-CH], tick3[ch-CH]};
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            for (int c = 0; c < NCH; c++) begin
                exp_t e;
                e.cyc = cyc; e.ch = c; e.val = model(c, cyc);
                sb.push_back(e);
            end
        end
    endtask

    task automatic run_to(input int t);
        step(t - cyc);
    endtask

    // Monitor: compare every expectation due this cycle.
    always @(negedge clk) begin : mon
        int i;
        if (run) begin
            i = 0;
            while (i < sb.size()) begin
                if (sb[i].cyc < cyc) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL missed ch%0d@%0d got=none exp=%b", sb[i].ch, sb[i].cyc, sb[i].val);
                    sb.delete(i);
                end else if (sb[i].cyc == cyc) begin
                    check($sformatf("ch%0d@%0d {div_clk,tick}", sb[i].ch, cyc),
                          32'(dut_out(sb[i].ch)), 32'(sb[i].val));
                    sb.delete(i);
                end else begin
                    i++;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        en = '1; mode = '0; wr_en = 0; wr_ch = '0; wr_div = '0; sync = 0;
        en3 = '1; mode3 = '0; wr_en3 = 0; wr_ch3 = '0; wr_div3 = '0; sync3 = 0;
        #23;
        check("reset div_clk", 32'(div_clk), 0);
        check("reset tick", 32'(tick), 0);
        check("reset div_clk3", 32'(div_clk3), 0);
        check("reset tick3", 32'(tick3), 0);

        // 1: default divisor everywhere, phase origin at the first edge.
        for (int c = 0; c < CH; c++) seg(c, 1, 1, 10, 0, 1);
        for (int c = CH; c < NCH; c++) seg(c, 1, 1, 4, 0, 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        run = 1;

        // 6b: out-of-range write on the 3-channel instance changes nothing.
        run_to(12);
        wr_en3 = 1; wr_ch3 = 2'd3; wr_div3 = 8'd2;
        step(1);
        wr_en3 = 0;

        // 2: ch1 div=7 mid-period; committed at the wrap on edge 40.
        run_to(33);
        seg(1, 41, 41, 7, 0, 1);
        wr_en = 1; wr_ch = 2'd1; wr_div = 17'd7;
        step(1);
        wr_en = 0;

        run_to(49);
        wr_en3 = 1; wr_ch3 = 2'd3; wr_div3 = 8'd0;
        step(1);
        wr_en3 = 0;

        // 3: ch2 div=0 -> 2 at wrap 80, then div=1 -> still 2.
        run_to(71);
        seg(2, 81, 81, 2, 0, 1);
        wr_en = 1; wr_ch = 2'd2; wr_div = 17'd0;
        step(1);
        wr_en = 0;
        run_to(84);
        wr_en = 1; wr_ch = 2'd2; wr_div = 17'd1;
        step(1);
        wr_en = 0;

        // 4: ch3 pulse mode, div=4, committed at wrap 100; back to toggle at wrap 120.
        run_to(92);
        seg(3, 101, 101, 4, 1, 1);
        wr_en = 1; wr_ch = 2'd3; wr_div = 17'd4; mode[3] = 1'b1;
        step(1);
        wr_en = 0;
        run_to(117);
        seg(3, 121, 121, 4, 0, 1);
        mode[3] = 1'b0;

        // 5: staggered enables, then sync together with a write to ch0.
        run_to(130);
        seg(0, 131, 0, 1, 0, 0);
        seg(1, 131, 0, 1, 0, 0);
        en[1:0] = 2'b00;
        run_to(134);
        seg(0, 135, 135, 10, 0, 1);
        en[0] = 1'b1;
        run_to(137);
        seg(1, 138, 138, 7, 0, 1);
        en[1] = 1'b1;
        run_to(150);
        seg(0, 151, 152, 7, 0, 1);
        seg(1, 151, 152, 7, 0, 1);
        seg(2, 151, 152, 2, 0, 1);
        seg(3, 151, 152, 4, 0, 1);
        sync = 1; wr_en = 1; wr_ch = 2'd0; wr_div = 17'd7;
        step(1);
        sync = 0; wr_en = 0;

        // 5b: ch1 disabled mid-period, re-enabled; first tick 7 edges later.
        run_to(170);
        seg(1, 171, 0, 1, 0, 0);
        en[1] = 1'b0;
        run_to(174);
        seg(1, 175, 175, 7, 0, 1);
        en[1] = 1'b1;

        // 6: async reset while ch0 is in its high phase (checked at edge 190).
        run_to(190);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("async rst div_clk", 32'(div_clk), 0);
        check("async rst tick", 32'(tick), 0);
        check("async rst div_clk3", 32'(div_clk3), 0);
        for (int c = 0; c < NCH; c++) seg(c, 191, 0, 1, 0, 0);
        step(3);
        for (int c = 0; c < CH; c++) seg(c, 194, 194, 10, 0, 1);
        for (int c = CH; c < NCH; c++) seg(c, 194, 194, 4, 0, 1);
        rst = 1'b1;
        run_to(215);

        @(negedge clk);
        #1;
        check("scoreboard drained", 32'(sb.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/clk_div_multi.md
Name: clk_div_multi

Overview:
- Multi-channel programmable clock divider and tick generator; successor to the fixed single-output 1 ms divider.
- CH independent channels, each with a run-time divisor, enable, and toggle (square-wave) or pulse (1-cycle tick) mode.
- Shared sync strobe phase-aligns all channels.
- Feeds timers, debouncers and display scanners in the car-simulation top level from the 100 MHz board clock.

Parameters:
- CH, 4, number of channels (1..16).
- CHW, 2, width of channel select; must satisfy 2^CHW >= CH.
- W, 17, divisor/counter width.
- DEFAULT_DIV, 100000, divisor loaded into every channel at reset (1 ms at 100 MHz); must satisfy 2 <= DEFAULT_DIV < 2^W.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset.
- en  in  CH  per-channel enable, level.
- mode  in  CH  per-channel mode: 0 = toggle, 1 = pulse.
- wr_en  in  1  divisor write strobe, one cycle.
- wr_ch  in  CHW  channel index for write.
- wr_div  in  W  new divisor value.
- sync  in  1  restart all channels, one cycle.
- div_clk  out  CH  divided clock (toggle mode) or copy of tick (pulse mode), registered.
- tick  out  CH  one-cycle period marker, registered.

Behaviour:
- Reset (rst low, async):
  - All counters = 0; div_clk = 0; tick = 0.
  - Active divisor and shadow divisor = DEFAULT_DIV; latched mode = 0.
- Per channel, registers:
  - cnt[W]: 0..div-1.
  - div_act: active divisor.
  - div_shd: pending divisor.
  - mode_act: latched mode.
- Write:
  - When wr_en=1 and wr_ch<CH, div_shd[wr_ch] <= clamp(wr_div).
  - clamp: values 0 and 1 become 2.
  - wr_ch>=CH is ignored with no side effects.
- Commit (div_act <= div_shd, mode_act <= mode) occurs on:
  - (a) wrap, i.e. cnt==div_act-1 while enabled;
  - (b) any cycle the channel is disabled;
  - (c) sync.
  - If a write to a channel coincides with a commit event, the written (clamped) value is committed directly that cycle.
- Disabled (en=0): cnt=0, div_clk=0, tick=0, held every cycle.
- Enabled, counting:
  - cnt increments by 1 each cycle.
  - At cnt==div_act-1, cnt wraps to 0.
  - tick is registered high for exactly the cycle after cnt==div_act-1, so period = div_act cycles.
- Toggle mode (mode_act=0), with h = div_act>>1:
  - div_clk toggles in the cycle after cnt==h-1 (goes 1) and after cnt==div_act-1 (goes 0).
  - Low phase = h cycles; high phase = div_act-h cycles.
  - Even divisors give 50% duty; odd divisors have the longer phase high.
- Pulse mode (mode_act=1): div_clk = tick.
- Mode change while running takes effect at the next commit. If div_clk is high when switching into pulse mode, it drops with the commit.
- Enable rising edge: first tick occurs div_act cycles after the first enabled cycle. First toggle high occurs h cycles after it.
- sync=1:
  - Next cycle, all enabled channels have cnt=0, div_clk=0, tick=0, and commits occur.
  - sync has priority over wrap.
  - Channels are phase-aligned afterwards.
- Simultaneous sync and wr_en: the write is committed, with sync semantics.
- Counter never exceeds div_act-1. On a commit mid-period (disable/sync), cnt restarts at 0, so no over-run occurs on a divisor shrink.
- Reset asserted mid-operation: outputs clear immediately (async). After deassertion, all channels run at DEFAULT_DIV.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
1. Bench with DEFAULT_DIV=10, CH=4; release reset, all en=1, mode=0 -> each div_clk has period 10, 5 high / 5 low, first rise 5 cycles after release; tick pulses every 10 cycles.
2. Write ch1 div=7 mid-period with mode 0 -> ch1 keeps period 10 until its next wrap, then period 7 (4 high / 3 low); other channels unaffected.
3. Write ch2 div=0, then div=1 -> both stored as 2; ch2 toggles every cycle (period 2), and tick fires every 2 cycles.
4. ch3 mode=1, div=4 -> div_clk[3] and tick[3] are 1-cycle pulses every 4 cycles. Toggle mode back to 0 -> square wave resumes after the next wrap.
5. Staggered enables on ch0/ch1, then pulse sync -> next cycle both cnt=0 and div_clk=0; subsequent ticks coincide. Also: en=0 mid-period -> outputs 0 next cycle, and first tick after re-enable arrives div_act cycles later.
6. Assert rst low during an active high phase -> div_clk/tick drop without a clock edge. wr_ch=3 with CH=3 -> no divisor changes.
